uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares a single `uart_tx` transmitter among `NUM_REQ` byte producers. It accepts one byte at a time from the winning requester and drives the transmitter's `tx_start`/`data_in` handshake. It then tracks the transmitter's `busy` flag until the frame completes. It sits between the on-chip producers (status reporters, debug dumps) and the one `uart_tx` instance driving the board TX pin.

---
 rtl/uart_tx_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers.
// Optional message lock is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [8*NUM_REQ-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]     i_req_last,
  output logic [NUM_REQ-1:0]     o_req_ready,
  input  logic                   i_tx_busy,
  output logic                   o_tx_start,
  output logic [7:0]             o_tx_data,
  output logic [2:0]             o_grant_id,
  output logic                   o_active,
  output logic                   o_err_timeout
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_rr_ptr;
  logic [CW-1:0]   r_cnt;
  logic            r_tx_start;
  logic [7:0]      r_tx_data;
  logic [2:0]      r_grant_id;
  logic            r_active;

  logic [7:0]      w_elig8;
  logic [7:0]      w_bytes [8];
  logic            w_found;
  logic [2:0]      w_winner;
  logic            w_grant;
  logic            w_timeout;

  // Wrap a scan position back into 0..NUM_REQ-1.
  function automatic logic [2:0] f_wrap(input logic [3:0] sum);
    if (sum >= 4'(NUM_REQ)) begin
      return 3'(sum - 4'(NUM_REQ));
    end else begin
      return sum[2:0];
    end
  endfunction

  for (genvar g = 0; g < 8; g++) begin : g_bytes
    if (g < NUM_REQ) begin : g_used
      assign w_bytes[g] = i_req_data[8*g +: 8];
    end else begin : g_pad
      assign w_bytes[g] = 8'd0;
    end
  end

`ifdef UART_ARB_LOCK_EN
  logic       r_locked;
  logic [2:0] r_lock_id;
  logic [7:0] w_last8;

  assign w_last8 = 8'(i_req_last);

  // While a message is in progress only its owner is eligible.
  always_comb begin
    w_elig8 = 8'(i_req_valid);
    if (r_locked) begin
      w_elig8 = 8'(i_req_valid) & (8'd1 << r_lock_id);
    end else begin
      w_elig8 = 8'(i_req_valid);
    end
  end

  // Lock follows the last-byte flag of each accepted byte; a timeout frees it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_locked  <= 1'b0;
      r_lock_id <= 3'd0;
    end else if (w_grant) begin
      r_locked  <= ~w_last8[w_winner];
      r_lock_id <= w_winner;
    end else if (w_timeout) begin
      r_locked  <= 1'b0;
    end
  end
`else
  logic w_unused_last;

  assign w_elig8       = 8'(i_req_valid);
  assign w_unused_last = ^i_req_last;
`endif

  // Round-robin scan starting just after the previous winner.
  always_comb begin
    logic [2:0] v_idx;
    v_idx    = 3'd0;
    w_found  = 1'b0;
    w_winner = 3'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_idx = f_wrap({1'b0, r_rr_ptr} + 4'(k));
      if (!w_found && w_elig8[v_idx]) begin
        w_found  = 1'b1;
        w_winner = v_idx;
      end else begin
        w_found  = w_found;
      end
    end
  end

  // Next-state logic; the grant is suppressed during reset so no byte is lost.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_tx_busy && w_found && !i_rst) begin
          w_grant     = 1'b1;
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (i_tx_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = ~i_rst;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_ACK;
        end
      end
      S_WAIT_DONE: begin
        if (!i_tx_busy) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // One-hot accept strobe for the winner in the grant cycle.
  always_comb begin
    o_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant && (w_winner == 3'(i))) begin
        o_req_ready[i] = 1'b1;
      end else begin
        o_req_ready[i] = 1'b0;
      end
    end
  end

  // State, pointer, captured byte and registered handshake outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= 3'(NUM_REQ - 1);
      r_cnt      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'd0;
      r_grant_id <= 3'd0;
      r_active   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_start <= (w_state_nxt == S_START);
      r_active   <= (w_state_nxt != S_IDLE);
      if (w_grant) begin
        r_tx_data  <= w_bytes[w_winner];
        r_grant_id <= w_winner;
        r_rr_ptr   <= w_winner;
      end
      if (r_state == S_START) begin
        r_cnt <= '0;
      end else if ((r_state == S_WAIT_ACK) && !i_tx_busy) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_tx_start    = r_tx_start;
  assign o_tx_data     = r_tx_data;
  assign o_grant_id    = r_grant_id;
  assign o_active      = r_active;
  assign o_err_timeout = w_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural uart_tx stub.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        tx_busy, tx_start, active, err_timeout;
  logic [7:0]  tx_data;
  logic [2:0]  grant_id;

  int total = 0;
  int bad   = 0;

  bit stub_on, stub_rand, force_busy;
  int fix_ack, fix_len;
  int ack_dly, flen, s_cnt;
  bit s_pend;
  logic [7:0] log_data[$];
  int         log_id[$];

  uart_tx_arbiter #(.NUM_REQ(N), .ACK_TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .i_req_last(req_last), .o_req_ready(req_ready), .i_tx_busy(tx_busy),
    .o_tx_start(tx_start), .o_tx_data(tx_data), .o_grant_id(grant_id),
    .o_active(active), .o_err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // uart_tx stand-in: logs each started byte, raises busy after ack_dly for flen cycles
  initial begin
    tx_busy = 1'b0; s_pend = 0; s_cnt = 0; ack_dly = 1; flen = 10;
    forever begin
      @(posedge clk); #1;
      if (tx_start === 1'b1) begin
        log_data.push_back(tx_data);
        log_id.push_back(int'(grant_id));
        s_pend = 1; s_cnt = 0;
        if (stub_rand) begin
          ack_dly = $urandom_range(0, 5); flen = $urandom_range(6, 24);
        end else begin
          ack_dly = fix_ack; flen = fix_len;
        end
      end else if (s_pend) begin
        s_cnt++;
      end
      if (!stub_on) begin
        s_pend = 0; tx_busy = force_busy;
      end else begin
        tx_busy = s_pend && (s_cnt >= ack_dly) && (s_cnt < ack_dly + flen);
        if (s_pend && (s_cnt >= ack_dly + flen)) s_pend = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    int k;
    rst = 1'b1; req_valid = 4'h0; req_last = 4'hF; req_data = 32'h0;
    stub_on = 1; force_busy = 0;
    repeat (n) tick();
    k = 0;
    while (s_pend && k < 300) begin tick(); k++; end
    rst = 1'b0;
    log_data.delete(); log_id.delete();
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((active !== 1'b0 || s_pend) && n < lim) begin tick(); n++; end
    total++;
    if (active !== 1'b0 || s_pend) begin
      bad++; $display("FAIL idle_wait: active=%b stub_pending=%0d, required idle", active, s_pend);
    end
  endtask

  function automatic int f_first(input logic [3:0] v, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic test_reset;
    for (int i = 0; i < 5; i++) begin
      tick(); req_valid = 4'($urandom); req_data = $urandom;
      @(negedge clk);
      total++;
      if ({req_ready, tx_start, tx_data, grant_id, active, err_timeout} !== 18'd0) begin
        bad++; $display("FAIL reset_outputs: ready=%b start=%b data=%h gid=%0d act=%b err=%b, required all 0",
                        req_ready, tx_start, tx_data, grant_id, active, err_timeout);
      end
    end
    tick(); rst = 1'b0; req_valid = 4'h0;
    @(negedge clk);
    total++;
    if (req_ready !== 4'h0 || active !== 1'b0 || tx_start !== 1'b0) begin
      bad++; $display("FAIL reset_release: ready=%b act=%b start=%b, required 0", req_ready, active, tx_start);
    end
  endtask

  task automatic test_single;
    int viol = 0, n = 0;
    do_reset(5);
    stub_rand = 0; fix_ack = 1; fix_len = 12;
    req_valid = 4'b0100; req_data = 32'h0; req_data[23:16] = 8'hA5;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0100) begin
      bad++; $display("FAIL single_ready: got %b required 0100", req_ready);
    end
    tick(); req_valid = 4'h0; req_data = 32'h0;
    @(negedge clk);
    total++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA5 || grant_id !== 3'd2 || req_ready !== 4'h0) begin
      bad++; $display("FAIL single_start: start=%b data=%h gid=%0d ready=%b, required 1 a5 2 0000",
                      tx_start, tx_data, grant_id, req_ready);
    end
    tick(); @(negedge clk);
    total++;
    if (tx_start !== 1'b0) begin
      bad++; $display("FAIL single_pulse: start=%b required 0", tx_start);
    end
    while (active === 1'b1 && n < 60) begin
      if (tx_data !== 8'hA5) viol++;
      tick(); n++;
    end
    total++;
    if (viol != 0 || active !== 1'b0) begin
      bad++; $display("FAIL single_hold: data changes=%0d active=%b, required 0 and idle", viol, active);
    end
    total++;
    if (log_data.size() != 1 || log_data[0] !== 8'hA5) begin
      bad++; $display("FAIL single_tx_byte: frames=%0d, required one frame of a5", log_data.size());
    end
  endtask

  task automatic test_fairness;
    int viol = 0, n = 0;
    do_reset(3);
    stub_rand = 1;
    req_valid = 4'hF; req_data = 32'h13121110;
    while (log_data.size() < 5 && n < 600) begin
      @(negedge clk);
      if (req_ready !== 4'h0 && (tx_busy || !$onehot(req_ready))) viol++;
      tick(); n++;
    end
    total++;
    if (viol != 0) begin
      bad++; $display("FAIL fair_ready_busy: violations=%0d required 0", viol);
    end
    total++;
    if (log_data.size() < 5) begin
      bad++; $display("FAIL fair_count: frames=%0d required 5", log_data.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (log_data[k] !== 8'(8'h10 + k % 4) || log_id[k] != k % 4) begin
          bad++; $display("FAIL fair_order[%0d]: got %h/id%0d required %h/id%0d",
                          k, log_data[k], log_id[k], 8'(8'h10 + k % 4), k % 4);
        end
      end
    end
    req_valid = 4'h0;
    wait_idle(200);
  endtask

  task automatic test_timeout;
    int first = -1, nerr = 0;
    logic [3:0] rdy17 = 4'hx;
    do_reset(3);
    stub_on = 0; force_busy = 0;
    tick();
    req_valid = 4'b0011; req_data = $urandom;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0001) begin
      bad++; $display("FAIL to_first_grant: got %b required 0001", req_ready);
    end
    tick(); req_valid = 4'b0010;
    @(negedge clk);
    total++;
    if (tx_start !== 1'b1) begin
      bad++; $display("FAIL to_start: got %b required 1", tx_start);
    end
    for (int j = 1; j <= 20; j++) begin
      tick(); @(negedge clk);
      if (err_timeout === 1'b1) begin
        if (first < 0) first = j;
        nerr++;
      end
      if (j == 17) rdy17 = req_ready;
    end
    total++;
    if (first != 16 || nerr != 1) begin
      bad++; $display("FAIL to_pulse: first at %0d count %0d, required at 16 count 1", first, nerr);
    end
    total++;
    if (rdy17 !== 4'b0010) begin
      bad++; $display("FAIL to_regrant: got %b required 0010", rdy17);
    end
    req_valid = 4'h0;
    wait_idle(80);
    stub_on = 1;
  endtask

  task automatic test_reset_midframe;
    int viol = 0, n = 0;
    logic [3:0] rdy_fall = 4'hx;
    logic [7:0] d1;
    do_reset(3);
    stub_rand = 0; fix_ack = 0; fix_len = 30;
    d1 = 8'($urandom);
    req_valid = 4'b1000; req_data = $urandom;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b1000) begin
      bad++; $display("FAIL mid_grant: got %b required 1000", req_ready);
    end
    tick(); req_valid = 4'b0010; req_data[15:8] = d1;
    repeat (6) tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    total++;
    if ({req_ready, tx_start, tx_data, grant_id, active, err_timeout} !== 18'd0) begin
      bad++; $display("FAIL mid_reset_vals: ready=%b start=%b data=%h gid=%0d act=%b err=%b, required all 0",
                      req_ready, tx_start, tx_data, grant_id, active, err_timeout);
    end
    while (n < 60) begin
      if (tx_busy !== 1'b1) begin rdy_fall = req_ready; break; end
      if (req_ready !== 4'h0 || tx_start !== 1'b0) viol++;
      tick(); @(negedge clk); n++;
    end
    total++;
    if (viol != 0) begin
      bad++; $display("FAIL mid_no_grant_busy: violations=%0d required 0", viol);
    end
    total++;
    if (rdy_fall !== 4'b0010) begin
      bad++; $display("FAIL mid_after_busy: ready=%b required 0010", rdy_fall);
    end
    tick(); req_valid = 4'h0;
    @(negedge clk);
    total++;
    if (tx_start !== 1'b1 || grant_id !== 3'd1 || tx_data !== d1) begin
      bad++; $display("FAIL mid_restart: start=%b gid=%0d data=%h, required 1 1 %h", tx_start, grant_id, tx_data, d1);
    end
    wait_idle(200);
  endtask

  task automatic test_message_lock;
    int n0 = 0, n1 = 0, n = 0;
    logic [3:0] rdy;
    logic [7:0] exp_d [5];
    int         exp_i [5];
`ifdef UART_ARB_LOCK_EN
    exp_d = '{8'h80, 8'h40, 8'h41, 8'h42, 8'h81};
    exp_i = '{0, 1, 1, 1, 0};
`else
    exp_d = '{8'h80, 8'h40, 8'h81, 8'h41, 8'h82};
    exp_i = '{0, 1, 0, 1, 0};
`endif
    do_reset(3);
    stub_rand = 1;
    req_valid = 4'b0011; req_last = 4'b1101;
    req_data = 32'h0; req_data[7:0] = 8'h80; req_data[15:8] = 8'h40;
    while (log_data.size() < 5 && n < 800) begin
      @(negedge clk); rdy = req_ready;
      tick(); n++;
      if (rdy[0]) n0++;
      if (rdy[1]) n1++;
      req_data[7:0]  = 8'(8'h80 + n0);
      req_data[15:8] = 8'(8'h40 + n1);
      req_valid[1]   = (n1 < 3);
      req_last[1]    = (n1 == 2);
    end
    total++;
    if (log_data.size() < 5) begin
      bad++; $display("FAIL lock_count: frames=%0d required 5", log_data.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (log_data[k] !== exp_d[k] || log_id[k] != exp_i[k]) begin
          bad++; $display("FAIL lock_order[%0d]: got %h/id%0d required %h/id%0d",
                          k, log_data[k], log_id[k], exp_d[k], exp_i[k]);
        end
      end
    end
    req_valid = 4'h0; req_last = 4'hF;
    wait_idle(200);
  endtask

  // Random producers checked cycle by cycle against a transaction-level model
  task automatic test_random_traffic;
    int qcnt [4];
    bit en;
    int planned = 0, accepted = 0, cyc = 0, w;
    bit m_idle = 1, m_seen = 0, done = 0;
    int m_ptr = N - 1, m_acc = 0, m_id = 0;
    logic [7:0] m_byte = 8'h0;
    logic [3:0] rdy, exp;
    do_reset(3);
    stub_rand = 1;
    for (int i = 0; i < N; i++) begin
      qcnt[i] = $urandom_range(2, 6); planned += qcnt[i];
      req_valid[i] = 1'b1; req_data[8*i +: 8] = 8'($urandom);
    end
    while (cyc < 4000) begin
      @(negedge clk);
      rdy = req_ready;
      if (m_idle) begin
        exp = 4'h0; w = -1;
        if (!tx_busy) w = f_first(req_valid, m_ptr);
        if (w >= 0) exp = 4'(1 << w);
        total++;
        if (rdy !== exp || tx_start !== 1'b0 || err_timeout !== 1'b0) begin
          bad++; $display("FAIL rand_idle c%0d: ready=%b start=%b err=%b, required %b 0 0",
                          cyc, rdy, tx_start, err_timeout, exp);
        end
        if (w >= 0) begin
          m_idle = 0; m_seen = 0; m_acc = cyc; m_ptr = w; m_id = w;
          m_byte = req_data[8*w +: 8]; accepted++;
        end
      end else begin
        total++;
        if (cyc == m_acc + 1) begin
          if (tx_start !== 1'b1 || tx_data !== m_byte || grant_id !== 3'(m_id) || rdy !== 4'h0) begin
            bad++; $display("FAIL rand_start c%0d: start=%b data=%h gid=%0d ready=%b, required 1 %h %0d 0000",
                            cyc, tx_start, tx_data, grant_id, rdy, m_byte, m_id);
          end
        end else if (tx_start !== 1'b0 || tx_data !== m_byte || rdy !== 4'h0 || err_timeout !== 1'b0) begin
          bad++; $display("FAIL rand_busy c%0d: start=%b data=%h ready=%b err=%b, required 0 %h 0000 0",
                          cyc, tx_start, tx_data, rdy, err_timeout, m_byte);
        end
        if (m_seen && !tx_busy) m_idle = 1;
        if (tx_busy && cyc > m_acc) m_seen = 1;
      end
      tick(); cyc++;
      for (int i = 0; i < N; i++) begin
        if (rdy[i]) begin
          qcnt[i]--; req_data[8*i +: 8] = 8'($urandom);
        end
        en = ($urandom_range(0, 3) != 0);
        req_valid[i] = (qcnt[i] > 0) && en;
      end
      if ((qcnt[0] + qcnt[1] + qcnt[2] + qcnt[3]) == 0 && m_idle) begin
        done = 1; break;
      end
    end
    total++;
    if (!done || accepted != planned) begin
      bad++; $display("FAIL rand_drain: done=%0d accepted=%0d, required 1 and %0d", done, accepted, planned);
    end
    req_valid = 4'h0;
    wait_idle(200);
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'h0; req_data = 32'h0; req_last = 4'hF;
    stub_on = 1; stub_rand = 0; force_busy = 0; fix_ack = 1; fix_len = 10;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_reset_midframe();
    test_message_lock();
    test_random_traffic();
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
